gpio_write_buffer: RTL and testbench

- Downstream consumer of the processor's memory-mapped GPIO write port (GPIOaddr/GPIO/GPIOEn).
- Captures every single-cycle GPIO write strobe into a show-ahead FIFO.
- Drains the FIFO to a slower peripheral sink through a valid/ready handshake, so CPU stores are never stalled and not lost until the FIFO overflows.
- Reports occupancy and a sticky overflow flag.

---
 rtl/gpio_pkg.sv | 17 +
 rtl/gpio_fifo_mem.sv | 27 ++
 rtl/gpio_write_buffer.sv | 99 +++++++++
 tb/tb_gpio_write_buffer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared widths, the GPIO write record and the occupancy-width helper for the GPIO write buffer.
package gpio_pkg;

   localparam int GPIO_ADDR_W = 32;
   localparam int GPIO_DATA_W = 8;

   typedef struct packed {
      logic [GPIO_ADDR_W-1:0] addr;
      logic [GPIO_DATA_W-1:0] data;
   } gpio_wr_t;

   // Width needed to hold an occupancy value from 0 up to and including depth.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/gpio_fifo_mem.sv
// Register array for the GPIO write buffer: one synchronous write port, one combinational read port.
// Each entry holds a packed {addr, data} record laid out like gpio_pkg::gpio_wr_t.
module gpio_fifo_mem
   import gpio_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int W     = $bits(gpio_wr_t),
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [PW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [PW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   // Storage is not reset; the buffer only ever reads entries it has written.
   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/gpio_write_buffer.sv
// Show-ahead FIFO capturing processor GPIO write strobes and draining them over valid/ready.
// Optional macro GPIO_WRITE_BYPASS_EN: an empty buffer passes a write straight through when the sink is ready.
module gpio_write_buffer
   import gpio_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = GPIO_ADDR_W,
   parameter int DATA_W = GPIO_DATA_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       GPIOEn,
   input  logic [ADDR_W-1:0]          GPIOaddr,
   input  logic [DATA_W-1:0]          GPIO,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ADDR_W-1:0]          out_addr,
   output logic [DATA_W-1:0]          out_data,
   output logic                       full,
   output logic                       empty,
   output logic [cnt_w(DEPTH)-1:0]    count,
   output logic                       overflow,
   input  logic                       clr_ovf
);

   // Handshake: the sink takes the head entry in any cycle where out_valid and out_ready
   // are both high; out_valid never drops and out_addr/out_data never change until then.

   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   localparam int W  = ADDR_W + DATA_W;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [W-1:0]  rd_word;
   logic          bypass;
   logic          pop;
   logic          push;
   logic          drop;

   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);

`ifdef GPIO_WRITE_BYPASS_EN
   assign bypass = empty & GPIOEn & out_ready;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed write is consumed directly by the sink and never touches storage.
   assign pop  = ~empty & out_ready;
   assign push = GPIOEn & ~bypass & (~full | pop);
   assign drop = GPIOEn & full & ~pop;

   gpio_fifo_mem #(
      .DEPTH (DEPTH),
      .W     (W)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata ({GPIOaddr, GPIO}),
      .raddr (rd_ptr),
      .rdata (rd_word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
         // A drop in the same cycle as a clear keeps the flag set.
         if (drop)         overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end

   always_comb begin
      out_valid = ~empty;
      out_addr  = '0;
      out_data  = '0;
      if (bypass) begin
         out_valid = 1'b1;
         out_addr  = GPIOaddr;
         out_data  = GPIO;
      end else if (!empty) begin
         out_addr  = rd_word[W-1:DATA_W];
         out_data  = rd_word[DATA_W-1:0];
      end
   end

endmodule

// File: tb/tb_gpio_write_buffer.sv
// Self-checking bench for gpio_write_buffer against a queue-based reference model.
module tb_gpio_write_buffer;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 8;
  localparam int W      = ADDR_W + DATA_W;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              GPIOEn;
  logic [ADDR_W-1:0] GPIOaddr;
  logic [DATA_W-1:0] GPIO;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              clr_ovf;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] rx_q[$];
  logic [W-1:0] sent_q[$];
  logic         exp_ovf;
  int           errors = 0;
  int           checks = 0;

  gpio_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .GPIOEn(GPIOEn), .GPIOaddr(GPIOaddr), .GPIO(GPIO),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- drivers and reference model ----------------
  task automatic set_in(input logic en, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic rdy, input logic clr);
    @(negedge clk);
    GPIOEn = en; GPIOaddr = a; GPIO = d; out_ready = rdy; clr_ovf = clr;
    #1;
  endtask

  task automatic tick();
    int n;
    logic byp, mpop, mpush, mdrop;
    logic [W-1:0] word;
    n     = exp_q.size();
    word  = {GPIOaddr, GPIO};
    byp   = 1'b0;
`ifdef GPIO_WRITE_BYPASS_EN
    byp   = (n == 0) && GPIOEn && out_ready;
`endif
    mpop  = (n > 0) && out_ready;
    mpush = GPIOEn && !byp && ((n < DEPTH) || mpop);
    mdrop = GPIOEn && (n == DEPTH) && !mpop;
    @(posedge clk);
    if (byp)  rx_q.push_back(word);
    if (mpop) rx_q.push_back(exp_q.pop_front());
    if (mpush) exp_q.push_back(word);
    if (mdrop) exp_ovf = 1'b1;
    else if (clr_ovf) exp_ovf = 1'b0;
  endtask

  task automatic strobe(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic rdy);
    set_in(1'b1, a, d, rdy, 1'b0);
    tick();
  endtask

  task automatic idle(input logic rdy);
    set_in(1'b0, $urandom, DATA_W'($urandom), rdy, 1'b0);
  endtask

  function automatic logic [W-1:0] exp_head();
    if (exp_q.size() > 0) return exp_q[0];
`ifdef GPIO_WRITE_BYPASS_EN
    if (GPIOEn && out_ready) return {GPIOaddr, GPIO};
`endif
    return '0;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    GPIOEn = 0; GPIOaddr = '0; GPIO = '0; out_ready = 0; clr_ovf = 0;
    rst = 1'b1;
    exp_q.delete(); exp_ovf = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    checks++; if ({out_addr, out_data} !== '0) begin errors++; $display("FAIL reset_head got=%h exp=0", {out_addr, out_data}); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] ref_w [3];
    ref_w[0] = {32'h100, 8'hA1}; ref_w[1] = {32'h101, 8'hA2}; ref_w[2] = {32'h102, 8'hA3};
    rx_q.delete();
    strobe(32'h100, 8'hA1, 1'b0);
    idle(1'b0);
    checks++; if (out_valid !== 1'b1 || {out_addr, out_data} !== ref_w[0]) begin
      errors++; $display("FAIL basic_latency got=%b/%h exp=1/%h", out_valid, {out_addr, out_data}, ref_w[0]); end
    strobe(32'h101, 8'hA2, 1'b0);
    strobe(32'h102, 8'hA3, 1'b0);
    idle(1'b0);
    checks++; if (count !== CW'(3)) begin errors++; $display("FAIL basic_count got=%0d exp=3", count); end
    checks++; if ({out_addr, out_data} !== ref_w[0]) begin errors++; $display("FAIL basic_head got=%h exp=%h", {out_addr, out_data}, ref_w[0]); end
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      checks++; if (out_valid !== 1'b1 || {out_addr, out_data} !== ref_w[i]) begin
        errors++; $display("FAIL basic_pop%0d got=%b/%h exp=1/%h", i, out_valid, {out_addr, out_data}, ref_w[i]); end
      tick();
    end
    idle(1'b0);
    checks++; if (empty !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained empty=%b valid=%b exp=1/0", empty, out_valid); end
    checks++; if (rx_q.size() != 3) begin errors++; $display("FAIL basic_rx_size got=%0d exp=3", rx_q.size()); end
  endtask

  task automatic test_overflow();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    rx_q.delete(); sent_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      a = $urandom; d = DATA_W'($urandom);
      sent_q.push_back({a, d});
      strobe(a, d, 1'b0);
    end
    strobe(32'h1FF, 8'hEE, 1'b0);
    idle(1'b0);
    checks++; if (full !== 1'b1 || count !== CW'(DEPTH)) begin errors++; $display("FAIL ovf_full full=%b count=%0d exp=1/%0d", full, count, DEPTH); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    // drop coinciding with clear: flag must survive
    set_in(1'b1, 32'h1234, 8'h56, 1'b0, 1'b1);
    tick();
    idle(1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_drop_vs_clr got=%b exp=1", overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      idle(1'b1);
      checks++; if ({out_addr, out_data} !== exp_head()) begin
        errors++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, {out_addr, out_data}, exp_head()); end
      tick();
    end
    checks++; if (rx_q.size() != sent_q.size()) begin errors++; $display("FAIL ovf_rx_size got=%0d exp=%0d", rx_q.size(), sent_q.size()); end
    for (int i = 0; i < sent_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== sent_q[i]) begin errors++; $display("FAIL ovf_rx%0d got=%h exp=%h", i, rx_q[i], sent_q[i]); end
    end
    set_in(1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    idle(1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_full_push_pop();
    rx_q.delete();
    for (int i = 0; i < DEPTH; i++) strobe($urandom, DATA_W'($urandom), 1'b0);
    strobe(32'h200, 8'h55, 1'b1);
    idle(1'b0);
    checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL fpp_count got=%0d exp=%0d", count, DEPTH); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf got=%b exp=0", overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      idle(1'b1);
      checks++; if ({out_addr, out_data} !== exp_head()) begin
        errors++; $display("FAIL fpp_drain%0d got=%h exp=%h", i, {out_addr, out_data}, exp_head()); end
      tick();
    end
    checks++; if (rx_q.size() == 0 || rx_q[rx_q.size()-1] !== {32'h200, 8'h55}) begin
      errors++; $display("FAIL fpp_last got=%h exp=%h", (rx_q.size() > 0) ? rx_q[rx_q.size()-1] : '0, {32'h200, 8'h55}); end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    rx_q.delete(); sent_q.delete();
    for (int i = 0; i < 20; i++) begin
      a = $urandom; d = DATA_W'($urandom);
      sent_q.push_back({a, d});
      set_in(1'b1, a, d, 1'b1, 1'b0);
      checks++; if (count > CW'(1)) begin errors++; $display("FAIL b2b_count%0d got=%0d exp<=1", i, count); end
      tick();
    end
    idle(1'b1);
    tick();
    idle(1'b0);
    checks++; if (rx_q.size() != 20) begin errors++; $display("FAIL b2b_rx_size got=%0d exp=20", rx_q.size()); end
    for (int i = 0; i < 20 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== sent_q[i]) begin errors++; $display("FAIL b2b_rx%0d got=%h exp=%h", i, rx_q[i], sent_q[i]); end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) strobe($urandom, DATA_W'($urandom), 1'b0);
    idle(1'b0);
    checks++; if (count !== CW'(5)) begin errors++; $display("FAIL arst_pre_count got=%0d exp=5", count); end
    #2 rst = 1'b1;
    #1;
    exp_q.delete(); exp_ovf = 1'b0;
    checks++; if (out_valid !== 1'b0 || empty !== 1'b1 || count !== '0) begin
      errors++; $display("FAIL arst_now valid=%b empty=%b count=%0d exp=0/1/0", out_valid, empty, count); end
    @(negedge clk);
    rst = 1'b0;
    set_in(1'b1, 32'h300, 8'h77, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_same_cycle got=%b exp=0", out_valid); end
    tick();
    idle(1'b0);
    checks++; if (out_valid !== 1'b1 || {out_addr, out_data} !== {32'h300, 8'h77}) begin
      errors++; $display("FAIL arst_next got=%b/%h exp=1/%h", out_valid, {out_addr, out_data}, {32'h300, 8'h77}); end
    idle(1'b1);
    tick();
  endtask

`ifdef GPIO_WRITE_BYPASS_EN
  task automatic test_bypass();
    idle(1'b0);
    set_in(1'b1, 32'h400, 8'h99, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1 || {out_addr, out_data} !== {32'h400, 8'h99}) begin
      errors++; $display("FAIL byp_same got=%b/%h exp=1/%h", out_valid, {out_addr, out_data}, {32'h400, 8'h99}); end
    tick();
    idle(1'b0);
    checks++; if (count !== '0 || out_valid !== 1'b0) begin errors++; $display("FAIL byp_count got=%0d/%b exp=0/0", count, out_valid); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 3) != 0), $urandom, DATA_W'($urandom),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
      checks++; if (count !== CW'(exp_q.size())) begin errors++; $display("FAIL rnd_count%0d got=%0d exp=%0d", i, count, exp_q.size()); end
      checks++; if (out_valid !== ((exp_q.size() > 0) || (exp_head() != '0 && exp_q.size() == 0))) begin
        errors++; $display("FAIL rnd_valid%0d got=%b size=%0d", i, out_valid, exp_q.size()); end
      checks++; if ({out_addr, out_data} !== exp_head()) begin errors++; $display("FAIL rnd_head%0d got=%h exp=%h", i, {out_addr, out_data}, exp_head()); end
      checks++; if (full !== (exp_q.size() == DEPTH) || empty !== (exp_q.size() == 0)) begin
        errors++; $display("FAIL rnd_flags%0d full=%b empty=%b size=%0d", i, full, empty, exp_q.size()); end
      checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL rnd_ovf%0d got=%b exp=%b", i, overflow, exp_ovf); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_async_reset();
`ifdef GPIO_WRITE_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
